// File: rtl/alu_ctrl.sv
// ---------------------------------------------------------------------------
// alu_ctrl
//   Command-side driver for a combinational alu. Accepts one operation per
//   cmd valid/ready handshake, presents opcode/operands to the alu from
//   registers, captures alu_f one cycle later and offers it on a res
//   valid/ready channel. An accumulator holds the last error-free result so
//   that operations can be chained (cmd_use_acc). DIV-by-zero and illegal
//   opcodes are flagged without consulting alu_f.
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   cmd_valid/ready  command handshake (ready only in IDLE)
//   cmd_oc           opcode 0 ADD,1 SUB,2 MUL,3 DIV,4 NOT,5 XOR,6 OR,7 AND
//   cmd_a, cmd_b     operands (cmd_a ignored when cmd_use_acc=1)
//   cmd_use_acc      take operand a from the accumulator
//   alu_oc/a/b       registered drive to the alu
//   alu_f            alu result
//   res_valid/ready  result handshake
//   res_data         result (0 on error)
//   res_err          DIV by zero or illegal opcode
//   acc              last error-free result
//   busy             state != IDLE
// ---------------------------------------------------------------------------
module alu_ctrl #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_oc,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  input  logic                  cmd_use_acc,
  output logic [3:0]            alu_oc,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_f,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_err,
  output logic [DATA_WIDTH-1:0] acc,
  output logic                  busy
);

  localparam logic [3:0] OC_DIV = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [3:0]            alu_oc_q, alu_oc_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
  logic                  err_q, err_d;
  logic                  res_valid_q, res_valid_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                  res_err_q, res_err_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;

  logic accept;
  logic res_take;
  logic cmd_err;

  // Handshake qualifiers
  assign accept   = cmd_valid & cmd_ready;
  assign res_take = res_valid_q & res_ready;

  // Errors are decided from the command itself so the alu output is never
  // trusted for an illegal opcode or a zero divisor.
  assign cmd_err = cmd_oc[3] | ((cmd_oc == OC_DIV) & (cmd_b == '0));

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept)   state_d = ST_EXEC;
      ST_EXEC:               state_d = ST_DONE;
      ST_DONE: if (res_take) state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    if (state_q == ST_IDLE) begin
      cmd_ready = 1'b1;
      busy      = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath next-state
  // -------------------------------------------------------------------------
  always_comb begin
    alu_oc_d    = alu_oc_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    err_d       = err_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    acc_d       = acc_q;

    // Alu inputs move only on an accept edge; an erroneous command drives
    // zeros so nothing undefined is presented to the alu.
    if (accept) begin
      err_d = cmd_err;
      if (cmd_err) begin
        alu_oc_d = '0;
        alu_a_d  = '0;
        alu_b_d  = '0;
      end else begin
        alu_oc_d = cmd_oc;
        alu_a_d  = cmd_use_acc ? acc_q : cmd_a;
        alu_b_d  = cmd_b;
      end
    end

    // Capture the alu result one cycle after accept.
    if (state_q == ST_EXEC) begin
      res_valid_d = 1'b1;
      res_err_d   = err_q;
      res_data_d  = err_q ? '0 : alu_f;
      if (!err_q) begin
        acc_d = alu_f;
      end
    end

    if ((state_q == ST_DONE) && res_take) begin
      res_valid_d = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_oc_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      acc_q       <= '0;
    end else begin
      alu_oc_q    <= alu_oc_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      err_q       <= err_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      acc_q       <= acc_d;
    end
  end

  assign alu_oc    = alu_oc_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign acc       = acc_q;

endmodule
